// File: rtl/invader_march_ctrl.sv
// invader_march_ctrl: steps a single row of invaders left/right across the screen.
// The row descends and reverses at each edge. A hit removes one invader. The wave ends
// when every invader is destroyed (CLEARED) or the row reaches Y_LIMIT (LANDED).
// Optional macro INVADER_SPEEDUP_EN: the step interval shrinks as invaders are destroyed.
module invader_march_ctrl #(
   parameter int unsigned NUM_INVADERS    = 10,
   parameter int unsigned X_RANGE         = 100,
   parameter int unsigned Y_LIMIT         = 400,
   parameter int unsigned STEP_X          = 4,
   parameter int unsigned STEP_Y          = 16,
   parameter int unsigned FRAMES_PER_STEP = 30,
   parameter int unsigned MIN_FRAMES      = 4
) (
   input  logic                    clk65MHz,
   input  logic                    rst_n,
   input  logic                    frame_tick,
   input  logic                    start,
   input  logic                    hit_valid,
   input  logic [3:0]              hit_idx,
   output logic [9:0]              xpos,
   output logic [9:0]              ypos,
   output logic [NUM_INVADERS-1:0] invader_enable,
   output logic                    dir_left,
   output logic                    wave_cleared,
   output logic                    landed
);

   localparam int unsigned CW = $clog2(FRAMES_PER_STEP + 1);

   typedef enum logic [1:0] {StIdle, StMarch, StCleared, StLanded} state_t;

   state_t                  state;
   logic [CW-1:0]           frame_cnt;
   logic [CW-1:0]           interval;
   logic                    step_due;
   logic                    descend;
   logic                    dir_step;
   logic                    land_step;
   logic [10:0]             x_wide;
   logic [10:0]             y_wide;
   logic [10:0]             x_step;
   logic [10:0]             y_step;
   logic [NUM_INVADERS-1:0] hit_mask;
   logic [NUM_INVADERS-1:0] en_hit;

`ifdef INVADER_SPEEDUP_EN
   logic [4:0]  alive_sum;
   logic [4:0]  alive_count;
   logic [4:0]  dead;
   logic [11:0] dead2;

   // Population count of the alive mask.
   always_comb begin
      alive_sum = '0;
      for (int i = 0; i < NUM_INVADERS; i++) begin
         alive_sum = alive_sum + 5'(invader_enable[i]);
      end
   end

   // Register the count so the interval logic sees a stable, one-cycle-old value.
   always_ff @(posedge clk65MHz or negedge rst_n) begin
      if (!rst_n) begin
         alive_count <= '0;
      end else begin
         alive_count <= alive_sum;
      end
   end

   // Interval = max(MIN_FRAMES, FRAMES_PER_STEP - 2*dead), evaluated without underflow.
   always_comb begin
      dead  = 5'(NUM_INVADERS) - alive_count;
      dead2 = {6'd0, dead, 1'b0};
      if (12'(MIN_FRAMES) + dead2 >= 12'(FRAMES_PER_STEP)) begin
         interval = CW'(MIN_FRAMES);
      end else begin
         interval = CW'(12'(FRAMES_PER_STEP) - dead2);
      end
   end
`else
   assign interval = CW'(FRAMES_PER_STEP);
`endif

   // Candidate step and hit results; 11-bit arithmetic so the additions never wrap.
   always_comb begin
      // >= rather than == so that a shrinking interval cannot strand the counter above it
      step_due = frame_tick && (({1'b0, frame_cnt} + 1'b1) >= {1'b0, interval});
      x_wide   = {1'b0, xpos};
      y_wide   = {1'b0, ypos};
      x_step   = x_wide;
      descend  = 1'b0;
      if (!dir_left) begin
         if (x_wide + 11'(STEP_X) <= 11'(X_RANGE)) begin
            x_step = x_wide + 11'(STEP_X);
         end else begin
            descend = 1'b1;
         end
      end else begin
         if (x_wide >= 11'(STEP_X)) begin
            x_step = x_wide - 11'(STEP_X);
         end else begin
            descend = 1'b1;
         end
      end
      y_step    = descend ? (y_wide + 11'(STEP_Y)) : y_wide;
      dir_step  = descend ? ~dir_left : dir_left;
      land_step = descend && (y_step >= 11'(Y_LIMIT));
      hit_mask  = '0;
      if (hit_valid && ({1'b0, hit_idx} < 5'(NUM_INVADERS))) begin
         hit_mask = NUM_INVADERS'(1) << hit_idx;
      end
      en_hit = invader_enable & ~hit_mask;
   end

   // Wave FSM with registered position, mask and status outputs.
   always_ff @(posedge clk65MHz or negedge rst_n) begin
      if (!rst_n) begin
         state          <= StIdle;
         xpos           <= '0;
         ypos           <= '0;
         invader_enable <= '0;
         dir_left       <= 1'b0;
         wave_cleared   <= 1'b0;
         landed         <= 1'b0;
         frame_cnt      <= '0;
      end else begin
         case (state)
            StMarch: begin
               invader_enable <= en_hit;
               if (step_due) begin
                  frame_cnt <= '0;
                  xpos      <= x_step[9:0];
                  ypos      <= y_step[9:0];
                  dir_left  <= dir_step;
               end else if (frame_tick) begin
                  frame_cnt <= frame_cnt + 1'b1;
               end
               // Clearing the last invader wins over a simultaneous landing.
               if (en_hit == '0) begin
                  state        <= StCleared;
                  wave_cleared <= 1'b1;
               end else if (step_due && land_step) begin
                  state  <= StLanded;
                  landed <= 1'b1;
               end
            end
            default: begin
               if (start) begin
                  state          <= StMarch;
                  xpos           <= '0;
                  ypos           <= '0;
                  invader_enable <= '1;
                  dir_left       <= 1'b0;
                  wave_cleared   <= 1'b0;
                  landed         <= 1'b0;
                  frame_cnt      <= '0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_invader_march_ctrl.sv
// Bench for invader_march_ctrl: a reference model pushes the expected outputs for each
// clock edge; a monitor pops and compares them. Tasks add direct checks of key values.
// Instance b uses Y_LIMIT=32 to reach the landed state quickly.
`timescale 1ns/1ps
module tb_invader_march_ctrl;

   localparam int N   = 10;
   localparam int FPS = 30;
   localparam int MNF = 4;
   localparam int XR  = 100;
   localparam int SX  = 4;
   localparam int SY  = 16;
   localparam int YL  = 400;

   typedef struct {
      int         x;
      int         y;
      logic [9:0] en;
      bit         dir;
      bit         wc;
      bit         ld;
   } exp_t;

   logic clk;
   logic rst_n;
   logic frame_tick, start, hit_valid;
   logic [3:0] hit_idx;
   logic [9:0] xpos, ypos;
   logic [N-1:0] en;
   logic dir_left, wave_cleared, landed;

   logic b_tick, b_start;
   logic [9:0] b_x, b_y;
   logic [N-1:0] b_en;
   logic b_dir, b_wc, b_landed;

   int n_cmp;
   int n_fail;
   exp_t exp_q[$];
   exp_t mon_e;

   // Reference model state
   int m_state;  // 0 idle, 1 march, 2 cleared, 3 landed
   int m_x, m_y, m_cnt, m_alive;
   bit m_dir;
   logic [N-1:0] m_en;

   invader_march_ctrl u_dut (
      .clk65MHz       (clk),
      .rst_n          (rst_n),
      .frame_tick     (frame_tick),
      .start          (start),
      .hit_valid      (hit_valid),
      .hit_idx        (hit_idx),
      .xpos           (xpos),
      .ypos           (ypos),
      .invader_enable (en),
      .dir_left       (dir_left),
      .wave_cleared   (wave_cleared),
      .landed         (landed)
   );

   invader_march_ctrl #(.Y_LIMIT(32)) u_dut_b (
      .clk65MHz       (clk),
      .rst_n          (rst_n),
      .frame_tick     (b_tick),
      .start          (b_start),
      .hit_valid      (1'b0),
      .hit_idx        (4'd0),
      .xpos           (b_x),
      .ypos           (b_y),
      .invader_enable (b_en),
      .dir_left       (b_dir),
      .wave_cleared   (b_wc),
      .landed         (b_landed)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   // Monitor: compare DUT a against the oldest expected entry after each edge.
   always @(posedge clk) begin
      #1;
      if (exp_q.size() != 0) begin
         mon_e = exp_q.pop_front();
         n_cmp++;
         if (xpos !== 10'(mon_e.x) || ypos !== 10'(mon_e.y) || en !== mon_e.en ||
             dir_left !== mon_e.dir || wave_cleared !== mon_e.wc || landed !== mon_e.ld) begin
            n_fail++;
            $display("FAIL scoreboard t=%0t: got x=%0d y=%0d en=%h dir=%b wc=%b ld=%b, want x=%0d y=%0d en=%h dir=%b wc=%b ld=%b",
                     $time, xpos, ypos, en, dir_left, wave_cleared, landed,
                     mon_e.x, mon_e.y, mon_e.en, mon_e.dir, mon_e.wc, mon_e.ld);
         end
      end
   end

   function automatic int model_interval();
      int v;
`ifdef INVADER_SPEEDUP_EN
      v = FPS - 2 * (N - m_alive);
      if (v < MNF) v = MNF;
`else
      v = FPS;
`endif
      return v;
   endfunction

   task automatic model_reset();
      m_state = 0; m_x = 0; m_y = 0; m_cnt = 0; m_alive = 0; m_dir = 1'b0; m_en = '0;
   endtask

   // Advance the model by one clock edge and queue the expected outputs.
   task automatic model_edge(input bit tk, input bit st, input bit hv, input logic [3:0] idx);
      int nx, ny, ns, nc;
      bit nd, desc, land;
      logic [N-1:0] ne;
      exp_t e;
      if (!rst_n) begin
         model_reset();
      end else begin
         nx = m_x; ny = m_y; ns = m_state; nc = m_cnt; nd = m_dir; ne = m_en;
         desc = 1'b0; land = 1'b0;
         if (m_state != 1) begin
            if (st) begin
               nx = 0; ny = 0; nd = 1'b0; ne = '1; nc = 0; ns = 1;
            end
         end else begin
            if (hv && int'(idx) < N) ne[idx] = 1'b0;
            if (tk) begin
               if (m_cnt == model_interval() - 1) begin
                  nc = 0;
                  if (!m_dir) begin
                     if (m_x + SX <= XR) nx = m_x + SX; else desc = 1'b1;
                  end else begin
                     if (m_x >= SX) nx = m_x - SX; else desc = 1'b1;
                  end
                  if (desc) begin
                     ny = m_y + SY;
                     nd = !m_dir;
                     land = (ny >= YL);
                  end
               end else begin
                  nc = m_cnt + 1;
               end
            end
            if (ne == '0) ns = 2;
            else if (land) ns = 3;
         end
         m_alive = $countones(m_en);
         m_x = nx; m_y = ny; m_state = ns; m_cnt = nc; m_dir = nd; m_en = ne;
      end
      e.x = m_x; e.y = m_y; e.en = m_en; e.dir = m_dir;
      e.wc = (m_state == 2); e.ld = (m_state == 3);
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit tk, input bit st, input bit hv, input logic [3:0] idx);
      frame_tick = tk; start = st; hit_valid = hv; hit_idx = idx;
      model_edge(tk, st, hv, idx);
      @(posedge clk);
      #1;
      frame_tick = 1'b0; start = 1'b0; hit_valid = 1'b0; hit_idx = 4'd0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; frame_tick = 1'b0; start = 1'b0; hit_valid = 1'b0; hit_idx = 4'd0;
      b_tick = 1'b0; b_start = 1'b0;
      model_reset();
      #2;
      n_cmp++;
      if (xpos !== 10'd0 || ypos !== 10'd0 || en !== '0 || dir_left !== 1'b0 ||
          wave_cleared !== 1'b0 || landed !== 1'b0 || b_en !== '0 || b_landed !== 1'b0) begin
         n_fail++;
         $display("FAIL reset: x=%0d y=%0d en=%h dir=%b wc=%b ld=%b b_en=%h, want all zero",
                  xpos, ypos, en, dir_left, wave_cleared, landed, b_en);
      end
      #5 rst_n = 1'b1;
      // Ticks and hits without start leave the block idle.
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 4'(i));
      n_cmp++;
      if (en !== '0 || xpos !== 10'd0) begin
         n_fail++;
         $display("FAIL idle_hold: en=%h x=%0d, want en=0 x=0", en, xpos);
      end
   endtask

   task automatic test_first_step();
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 29; i++) drive(1'b1, 1'b0, 1'b0, 4'd0);
      n_cmp++;
      if (xpos !== 10'd0) begin
         n_fail++;
         $display("FAIL pre_step: x=%0d after 29 ticks, want 0", xpos);
      end
      drive(1'b1, 1'b0, 1'b0, 4'd0);
      n_cmp++;
      if (xpos !== 10'd4 || ypos !== 10'd0 || en !== 10'h3FF) begin
         n_fail++;
         $display("FAIL first_step: x=%0d y=%0d en=%h, want x=4 y=0 en=3ff", xpos, ypos, en);
      end
      // start while marching is ignored
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      n_cmp++;
      if (xpos !== 10'd4) begin
         n_fail++;
         $display("FAIL start_in_march: x=%0d, want 4", xpos);
      end
   endtask

   task automatic test_edge_descend();
      repeat (24 * FPS) drive(1'b1, 1'b0, 1'b0, 4'd0);
      n_cmp++;
      if (xpos !== 10'd100 || ypos !== 10'd0 || dir_left !== 1'b0) begin
         n_fail++;
         $display("FAIL right_edge: x=%0d y=%0d dir=%b, want x=100 y=0 dir=0", xpos, ypos, dir_left);
      end
      repeat (FPS) drive(1'b1, 1'b0, 1'b0, 4'd0);
      n_cmp++;
      if (xpos !== 10'd100 || ypos !== 10'd16 || dir_left !== 1'b1) begin
         n_fail++;
         $display("FAIL descend: x=%0d y=%0d dir=%b, want x=100 y=16 dir=1", xpos, ypos, dir_left);
      end
      repeat (FPS) drive(1'b1, 1'b0, 1'b0, 4'd0);
      n_cmp++;
      if (xpos !== 10'd96 || ypos !== 10'd16) begin
         n_fail++;
         $display("FAIL left_step: x=%0d y=%0d, want x=96 y=16", xpos, ypos);
      end
   endtask

   task automatic test_hits();
      logic [3:0] seq [3];
      seq[0] = 4'd3; seq[1] = 4'd3; seq[2] = 4'd12;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 1'b1, seq[i]);
         n_cmp++;
         if (en !== 10'h3F7) begin
            n_fail++;
            $display("FAIL hit_%0d idx=%0d: en=%h, want 3f7", i, seq[i], en);
         end
      end
   endtask

   task automatic test_clear();
      logic [3:0] kills [8];
      kills[0] = 4'd0; kills[1] = 4'd1; kills[2] = 4'd2; kills[3] = 4'd4;
      kills[4] = 4'd5; kills[5] = 4'd6; kills[6] = 4'd7; kills[7] = 4'd8;
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b1, kills[i]);
      n_cmp++;
      if (en !== 10'h200 || wave_cleared !== 1'b0) begin
         n_fail++;
         $display("FAIL one_left: en=%h wc=%b, want en=200 wc=0", en, wave_cleared);
      end
      // Tick up to the frame just before the step, then hit the last invader on the step.
      for (int g = 0; g < 64 && m_cnt != model_interval() - 1; g++) drive(1'b1, 1'b0, 1'b0, 4'd0);
      drive(1'b1, 1'b0, 1'b1, 4'd9);
      n_cmp++;
      if (wave_cleared !== 1'b1 || landed !== 1'b0 || en !== '0 || xpos !== 10'd92 ||
          ypos !== 10'd16) begin
         n_fail++;
         $display("FAIL clear_with_step: wc=%b ld=%b en=%h x=%0d y=%0d, want wc=1 ld=0 en=0 x=92 y=16",
                  wave_cleared, landed, en, xpos, ypos);
      end
      for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 1'b1, 4'(i % 10));
      n_cmp++;
      if (wave_cleared !== 1'b1 || en !== '0 || xpos !== 10'd92 || ypos !== 10'd16) begin
         n_fail++;
         $display("FAIL cleared_hold: wc=%b en=%h x=%0d y=%0d, want wc=1 en=0 x=92 y=16",
                  wave_cleared, en, xpos, ypos);
      end
   endtask

   task automatic test_speed();
      int n, want1, want2;
      logic [9:0] x0;
`ifdef INVADER_SPEEDUP_EN
      want1 = 20; want2 = 12;
`else
      want1 = FPS; want2 = FPS;
`endif
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      n_cmp++;
      if (en !== 10'h3FF || xpos !== 10'd0 || ypos !== 10'd0 || wave_cleared !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_from_cleared: en=%h x=%0d y=%0d wc=%b, want en=3ff x=0 y=0 wc=0",
                  en, xpos, ypos, wave_cleared);
      end
      for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 1'b1, 4'(i));
      drive(1'b0, 1'b0, 1'b0, 4'd0);
      x0 = xpos; n = 0;
      while (xpos === x0 && n < 100) begin
         drive(1'b1, 1'b0, 1'b0, 4'd0);
         n++;
      end
      n_cmp++;
      if (n != want1) begin
         n_fail++;
         $display("FAIL interval_5_dead: %0d ticks per step, want %0d", n, want1);
      end
      for (int i = 5; i < 9; i++) drive(1'b0, 1'b0, 1'b1, 4'(i));
      drive(1'b0, 1'b0, 1'b0, 4'd0);
      x0 = xpos; n = 0;
      while (xpos === x0 && n < 100) begin
         drive(1'b1, 1'b0, 1'b0, 4'd0);
         n++;
      end
      n_cmp++;
      if (n != want2) begin
         n_fail++;
         $display("FAIL interval_9_dead: %0d ticks per step, want %0d", n, want2);
      end
   endtask

   task automatic test_reset_midwave();
      rst_n = 1'b0;
      model_reset();
      #1;
      n_cmp++;
      if (xpos !== 10'd0 || ypos !== 10'd0 || en !== '0 || dir_left !== 1'b0 ||
          wave_cleared !== 1'b0 || landed !== 1'b0) begin
         n_fail++;
         $display("FAIL async_reset: x=%0d y=%0d en=%h dir=%b wc=%b ld=%b, want all zero",
                  xpos, ypos, en, dir_left, wave_cleared, landed);
      end
      #1 rst_n = 1'b1;
      for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 1'b1, 4'd2);
      n_cmp++;
      if (en !== '0 || xpos !== 10'd0) begin
         n_fail++;
         $display("FAIL idle_after_reset: en=%h x=%0d, want en=0 x=0", en, xpos);
      end
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      n_cmp++;
      if (en !== 10'h3FF) begin
         n_fail++;
         $display("FAIL start_after_reset: en=%h, want 3ff", en);
      end
   endtask

   // Instance b (Y_LIMIT=32) lands on the second descent, after 52 steps.
   task automatic b_cycle(input bit tk, input bit st);
      b_tick = tk; b_start = st;
      drive(1'b0, 1'b0, 1'b0, 4'd0);
      b_tick = 1'b0; b_start = 1'b0;
   endtask

   task automatic test_land();
      b_cycle(1'b0, 1'b1);
      repeat (52 * FPS - 1) b_cycle(1'b1, 1'b0);
      n_cmp++;
      if (b_landed !== 1'b0 || b_y !== 10'd16 || b_x !== 10'd0) begin
         n_fail++;
         $display("FAIL pre_land: ld=%b y=%0d x=%0d, want ld=0 y=16 x=0", b_landed, b_y, b_x);
      end
      b_cycle(1'b1, 1'b0);
      n_cmp++;
      if (b_landed !== 1'b1 || b_y !== 10'd32 || b_x !== 10'd0 || b_wc !== 1'b0) begin
         n_fail++;
         $display("FAIL land: ld=%b y=%0d x=%0d wc=%b, want ld=1 y=32 x=0 wc=0",
                  b_landed, b_y, b_x, b_wc);
      end
      repeat (40) b_cycle(1'b1, 1'b0);
      n_cmp++;
      if (b_landed !== 1'b1 || b_y !== 10'd32 || b_x !== 10'd0 || b_en !== 10'h3FF) begin
         n_fail++;
         $display("FAIL landed_hold: ld=%b y=%0d x=%0d en=%h, want ld=1 y=32 x=0 en=3ff",
                  b_landed, b_y, b_x, b_en);
      end
      b_cycle(1'b0, 1'b1);
      n_cmp++;
      if (b_landed !== 1'b0 || b_y !== 10'd0 || b_x !== 10'd0 || b_en !== 10'h3FF ||
          b_dir !== 1'b0) begin
         n_fail++;
         $display("FAIL restart_from_landed: ld=%b y=%0d x=%0d en=%h dir=%b, want ld=0 y=0 x=0 en=3ff dir=0",
                  b_landed, b_y, b_x, b_en, b_dir);
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      test_reset();
      test_first_step();
      test_edge_descend();
      test_hits();
      test_clear();
      test_speed();
      test_reset_midwave();
      test_land();
      #20;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
